// File: rtl/stdp_weight_update.sv
// STDP weight update engine: after a gamma cycle, walks every synapse of the
// winning neuron, reading each weight and writing it back potentiated or depressed.
module stdp_weight_update #(
  parameter int unsigned NEURONS = 16,
  parameter int unsigned LOG_N   = 4,
  parameter int unsigned INPUTS  = 64,
  parameter int unsigned LOG_I   = 6,
  parameter int unsigned T_BITS  = 4,
  parameter int unsigned W_BITS  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LOG_N:0]             winning_neuron,
  input  logic [T_BITS-1:0]          output_spike_time,
  input  logic [INPUTS-1:0]          in_spiked,
  input  logic [INPUTS*T_BITS-1:0]   in_spike_time,
  output logic                       w_rd_en,
  output logic [LOG_N+LOG_I-1:0]     w_rd_addr,
  input  logic [W_BITS-1:0]          w_rd_data,
  output logic                       w_wr_en,
  output logic [LOG_N+LOG_I-1:0]     w_wr_addr,
  output logic [W_BITS-1:0]          w_wr_data,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned A_BITS   = LOG_N + LOG_I;
  localparam int unsigned WIN_BITS = LOG_N + 1;
  localparam logic [W_BITS-1:0] W_MAX = {W_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [LOG_I-1:0]         idx_q, idx_d;
  logic [LOG_N-1:0]         win_q, win_d;
  logic [T_BITS-1:0]        t_out_q, t_out_d;
  logic [INPUTS-1:0]        spiked_q, spiked_d;
  logic [INPUTS*T_BITS-1:0] times_q, times_d;
  logic [A_BITS-1:0]        rd_addr_d, wr_addr_d;
  logic                     rd_en_d, wr_en_d, busy_d, done_d;

  logic                     sel_spiked;
  logic [T_BITS-1:0]        sel_time;
  logic                     potentiate;

  // Next-state, latching and registered-output decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    win_d     = win_q;
    t_out_d   = t_out_q;
    spiked_d  = spiked_q;
    times_d   = times_q;
    rd_addr_d = w_rd_addr;
    wr_addr_d = w_wr_addr;

    case (state_q)
      IDLE: begin
        if (start) begin
          win_d    = winning_neuron[LOG_N-1:0];
          t_out_d  = output_spike_time;
          spiked_d = in_spiked;
          times_d  = in_spike_time;
          idx_d    = '0;
          state_d  = (winning_neuron < WIN_BITS'(NEURONS)) ? READ : DONE;
        end
      end
      READ:  state_d = WRITE;
      WRITE: begin
        if (idx_q == LOG_I'(INPUTS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + LOG_I'(1);
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_en_d = (state_d == READ);
    wr_en_d = (state_d == WRITE);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    if (state_d == READ) begin
      rd_addr_d = A_BITS'(win_d) * A_BITS'(INPUTS) + A_BITS'(idx_d);
    end
    if (state_d == WRITE) begin
      wr_addr_d = w_rd_addr;
    end
  end

  // State, latched operands and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      win_q     <= '0;
      t_out_q   <= '0;
      spiked_q  <= '0;
      times_q   <= '0;
      w_rd_en   <= 1'b0;
      w_rd_addr <= '0;
      w_wr_en   <= 1'b0;
      w_wr_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      win_q     <= win_d;
      t_out_q   <= t_out_d;
      spiked_q  <= spiked_d;
      times_q   <= times_d;
      w_rd_en   <= rd_en_d;
      w_rd_addr <= rd_addr_d;
      w_wr_en   <= wr_en_d;
      w_wr_addr <= wr_addr_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Saturating weight update; read data only becomes valid in WRITE, so this is combinational
  always_comb begin
    sel_spiked = spiked_q[idx_q];
    sel_time   = times_q[idx_q*T_BITS +: T_BITS];
    potentiate = sel_spiked && (sel_time <= t_out_q);
    w_wr_data  = '0;
    if (state_q == WRITE) begin
      if (potentiate) begin
        w_wr_data = (w_rd_data == W_MAX) ? W_MAX : w_rd_data + W_BITS'(1);
      end else begin
        w_wr_data = (w_rd_data == '0) ? '0 : w_rd_data - W_BITS'(1);
      end
    end
  end

endmodule

// File: doc/stdp_weight_update.md
STDP_WEIGHT_UPDATE -- requirements
Module: stdp_weight_update

Interface
REQ-001 SHALL have parameter NEURONS, default 16, number of neurons in the layer.
REQ-002 SHALL have parameter LOG_N, default 4, log2(NEURONS); winner index is LOG_N+1 bits wide, all-ones = no winner.
REQ-003 SHALL have parameter INPUTS, default 64, synapses per neuron; LOG_I default 6 = log2(INPUTS).
REQ-004 SHALL have parameter T_BITS, default 4, spike-time width; W_BITS, default 3, weight width; W_MAX = 2^W_BITS-1.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse at end of gamma cycle requesting an update.
REQ-007 winning_neuron  input  LOG_N+1  winner from lateral inhibition, all-ones = none.
REQ-008 output_spike_time  input  T_BITS  winner's spike time.
REQ-009 in_spiked  input  INPUTS  bit i set = input i spiked this gamma cycle.
REQ-010 in_spike_time  input  INPUTS*T_BITS  flattened spike times, input i at bits [i*T_BITS +: T_BITS].
REQ-011 w_rd_en  output  1; w_rd_addr  output  LOG_N+LOG_I  weight read port, address = neuron*INPUTS + i.
REQ-012 w_rd_data  input  W_BITS  read data, valid exactly one cycle after w_rd_en.
REQ-013 w_wr_en  output  1; w_wr_addr  output  LOG_N+LOG_I; w_wr_data  output  W_BITS  weight write port.
REQ-014 busy  output  1  high in any state except IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-016 In IDLE, start=1 SHALL latch winning_neuron, output_spike_time, in_spiked, in_spike_time and clear index i to 0.
REQ-017 On start in IDLE with a valid winner (value < NEURONS), next state SHALL be READ.
REQ-018 On start with winner all-ones or >= NEURONS, next state SHALL be DONE; no read or write is issued.
REQ-019 In READ SHALL assert w_rd_en for one cycle with w_rd_addr = winner*INPUTS + i; next state WRITE.
REQ-020 In WRITE SHALL assert w_wr_en with w_wr_addr equal to the preceding read address and w_wr_data = updated weight.
REQ-021 Update rule: in_spiked[i]=1 and t_in <= t_out -> w+1, saturating at W_MAX.
REQ-022 Update rule: in_spiked[i]=1 and t_in > t_out -> w-1, saturating at 0.
REQ-023 Update rule: in_spiked[i]=0 -> w-1, saturating at 0.
REQ-024 Time comparison SHALL be unsigned over T_BITS; weight arithmetic SHALL never wrap.
REQ-025 From WRITE, if i = INPUTS-1, next state SHALL be DONE; otherwise i increments and next state is READ.
REQ-026 In DONE SHALL assert done for exactly one cycle; next state IDLE.
REQ-027 Update latency with a valid winner SHALL be 2*INPUTS+1 cycles from the start cycle to the done cycle, inclusive of done.
REQ-028 start while busy=1 SHALL be ignored; latched values SHALL NOT change until IDLE.
REQ-029 w_rd_en and w_wr_en SHALL never be high in the same cycle; outside READ/WRITE both SHALL be 0.
REQ-030 Only the latched winner's INPUTS synapses SHALL be written; every one of them is written exactly once per update.

Reset
REQ-031 rst=1 SHALL force IDLE, i=0, and busy, done, w_rd_en, w_wr_en to 0 on the next clock edge.
REQ-032 Latched winner/time registers and address outputs SHALL reset to 0.
REQ-033 rst during READ or WRITE SHALL abort the update; no further writes and no done pulse are produced.
REQ-034 rst has priority over start in the same cycle.

Verification
REQ-035 Winner 3, t_out=5, input 0 spiked at t=2, weight 4 -> write addr 192 data 5; input 1 spiked t=7, weight 4 -> addr 193 data 3.
REQ-036 Saturation: potentiate weight 7 -> writes 7; depress weight 0 (input not spiked) -> writes 0.
REQ-037 start with winning_neuron=5'b11111 -> done one cycle later, zero reads/writes, busy high for that one cycle only.
REQ-038 Full sweep, winner 15, INPUTS=64 -> 64 reads, 64 writes at addrs 960..1023 in order, done on cycle 129 after start.
REQ-039 Second start pulse at cycle 10 of an active update -> ignored, write count remains 64, latched winner unchanged.
REQ-040 rst asserted in WRITE at i=20 -> all outputs 0 next cycle, no done, then new start completes normally.
